alu_serie_ctrl: RTL and testbench
=================================

# alu_serie_ctrl

Bit-serial N-bit arithmetic/logic unit. One internal `cal` cell (full adder plus logic cell behind a 2:1 mux) processes one bit per clock, LSB first. The block holds the operand and result shift registers, the inter-bit carry flip-flop, the bit counter and the start/done handshake. It sits between a register file or test sequencer and the single shared cell, trading N cycles of latency for one cell of area.

## Interface
- `N`, default 8: operand width in bits, minimum 2. The counter is `$clog2(N)` bits wide.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `start` in 1: request a new operation; sampled only in IDLE.
- `a` in N: operand A, latched at start.
- `b` in N: operand B, latched at start.
- `l` in 1: operation class, latched at start. 1 = logic (cell `cl` path), 0 = arithmetic (cell `fa` path).
- `s` in 2: logic function select, passed unchanged to the cell for the whole operation.
- `sub` in 1: when `l=0`, 1 = A−B (two's complement); ignored when `l=1`.
- `y` out N: result, valid while `done=1` and held until the next accepted start.
- `c_out` out 1: final carry out of the MSB. Arithmetic only; 0 for logic operations.
- `ov` out 1: signed overflow. Arithmetic only; 0 for logic operations.
- `busy` out 1: high in RUN and DONE.
- `done` out 1: high for exactly one cycle, in DONE.

## Operation
- States are IDLE, RUN and DONE; reset enters IDLE.
- IDLE with `start=1` at an edge:
  - load shift registers SA←`a`, SB←`b`;
  - latch `l`, `s` and `sub`;
  - counter←0;
  - carry FF←(`sub & ~l`);
  - go to RUN.
- IDLE with `start=0`: stay in IDLE. `start` in RUN or DONE is ignored; it is neither queued nor an error.
- RUN, each edge:
  - Cell inputs: a=SA[0]; b=SB[0] ^ (`sub & ~l`); l and s as latched; c_in=carry FF when `l=0`, 0 when `l=1`.
  - Result register shifts right, with cell `out` entering at bit N−1.
  - SA and SB shift right.
  - Carry FF←cell `c_out` when `l=0`; held at 0 when `l=1`.
  - When counter=N−1, record ovr = (carry FF ^ cell `c_out`), i.e. carry into the MSB XOR carry out of the MSB, and capture final `c_out`. Both are 0 when `l=1`.
  - Counter increments. On the edge where counter=N−1, go to DONE.
- DONE: `done=1`, `y`/`c_out`/`ov` valid. The next edge always goes to IDLE.
- Arithmetic is modulo 2^N.
- Subtraction is A + ~B + 1. `c_out=1` means no borrow.
- Outputs `y`, `c_out` and `ov` are registered and change only on the edge that enters DONE, or on reset.

## Timing
- Reset values, asserted immediately and asynchronously:
  - state=IDLE;
  - `y`=0, `c_out`=0, `ov`=0, `busy`=0, `done`=0;
  - SA, SB, carry FF and counter all 0.
- If start is accepted at edge E0:
  - `busy`=1 after E0;
  - bit i is processed at edge E0+1+i, for i=0..N−1;
  - `done`=1 during the cycle after edge E0+N;
  - `busy`=0 and `done`=0 after edge E0+N+1.
- Latency from the start edge to `done` is N cycles. Minimum start-to-start spacing is N+2 cycles: the earliest next acceptance is edge E0+N+2 if `start` is held.
- `reset_n` low mid-RUN or in DONE aborts the operation with no done pulse. After release, the first start runs normally.
- Operand inputs may change freely after the start edge.

## Test plan
- Add, N=8, a=0x5A, b=0x3C, l=0, sub=0 → `y`=0x96, `c_out`=0, `ov`=1; `done` exactly one cycle, 8 cycles after the start edge.
- Add wrap: a=0xFF, b=0x01 → `y`=0x00, `c_out`=1, `ov`=0. Sub: a=0x10, b=0x01, sub=1 → `y`=0x0F, `c_out`=1, `ov`=0.
- Sub overflow: a=0x80, b=0x01, sub=1 → `y`=0x7F, `c_out`=1, `ov`=1. Sub borrow: a=0x00, b=0x01 → `y`=0xFF, `c_out`=0, `ov`=0.
- Logic: a=0xF0, b=0xCC, l=1, s=0..3 → each `y` bit equals cl(a_i, b_i, s) from the cell model; `c_out`=0 and `ov`=0 even with sub=1.
- Start pulsed with a=0x01, b=0x01 during RUN and during DONE → ignored; the first result is unchanged and `busy` returns to 0 for at least one cycle. `start` held high → back-to-back operations spaced N+2 cycles apart.
- `reset_n` pulsed low after 4 bits of a=0x5A+0x3C → all outputs 0 at once and no `done` pulse. A following a=0x01+0x02 gives `y`=0x03.

Source files
------------

// File: rtl/alu_serie_ctrl.sv
// alu_serie_ctrl: bit-serial N-bit ALU, one shared full-adder/logic cell processing one bit per clock, LSB first.
module alu_serie_cal (
  input  logic       a,
  input  logic       b,
  input  logic       c_in,
  input  logic       l,
  input  logic [1:0] s,
  output logic       out,
  output logic       c_out
);
  logic fa_sum, fa_co, cl;
  always_comb begin
    fa_sum = a ^ b ^ c_in;
    fa_co  = (a & b) | ((a ^ b) & c_in);
    cl     = (s == 2'd0) ? (a & b) :
             (s == 2'd1) ? (a | b) :
             (s == 2'd2) ? (a ^ b) : ~(a & b);
    out    = l ? cl : fa_sum;
    c_out  = l ? 1'b0 : fa_co;
  end
endmodule

module alu_serie_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         l,
  input  logic [1:0]   s,
  input  logic         sub,
  output logic [N-1:0] y,
  output logic         c_out,
  output logic         ov,
  output logic         busy,
  output logic         done
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;

  logic [N-1:0]  sa_q, sb_q, r_q, y_q;
  logic [CW-1:0] cnt_q;
  logic          carry_q, l_q, sub_q, cout_q, ov_q;
  logic [1:0]    s_q;
  logic          last, inv, cell_out, cell_co;

  assign last = (cnt_q == LAST);
  assign inv  = sub_q & ~l_q;

  alu_serie_cal u_cal (
    .a     (sa_q[0]),
    .b     (sb_q[0] ^ inv),
    .c_in  (carry_q & ~l_q),
    .l     (l_q),
    .s     (s_q),
    .out   (cell_out),
    .c_out (cell_co)
  );

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;

  always_comb begin
    state_d = (state_q == IDLE) ? (start ? RUN : IDLE) :
              (state_q == RUN)  ? (last ? DONE : RUN) : IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sa_q    <= '0;
      sb_q    <= '0;
      r_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      l_q     <= 1'b0;
      s_q     <= 2'd0;
      sub_q   <= 1'b0;
      cout_q  <= 1'b0;
      ov_q    <= 1'b0;
    end else if (state_q == IDLE && start) begin
      sa_q    <= a;
      sb_q    <= b;
      l_q     <= l;
      s_q     <= s;
      sub_q   <= sub;
      cnt_q   <= '0;
      carry_q <= sub & ~l;
    end else if (state_q == RUN) begin
      sa_q    <= sa_q >> 1;
      sb_q    <= sb_q >> 1;
      r_q     <= {cell_out, r_q[N-1:1]};
      carry_q <= cell_co;
      cnt_q   <= cnt_q + CW'(1);
      // outputs are only published on the final bit so y stays stable during RUN
      if (last) begin
        y_q    <= {cell_out, r_q[N-1:1]};
        cout_q <= cell_co;
        ov_q   <= carry_q ^ cell_co;
      end
    end
  end

  assign y     = y_q;
  assign c_out = cout_q;
  assign ov    = ov_q;
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
endmodule

// File: tb/tb_alu_serie_ctrl.sv
// tb_alu_serie_ctrl: directed vectors with hand-computed results for the bit-serial ALU.
module tb_alu_serie_ctrl;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] a = '0, b = '0;
  logic         l = 1'b0, sub = 1'b0;
  logic [1:0]   s = 2'd0;
  logic [N-1:0] y;
  logic         c_out, ov, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  alu_serie_ctrl #(.N(N)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b), .l(l), .s(s),
    .sub(sub), .y(y), .c_out(c_out), .ov(ov), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [7:0] ta, input logic [7:0] tb_, input logic tl,
                       input logic [1:0] ts, input logic tsub);
    a = ta; b = tb_; l = tl; s = ts; sub = tsub; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~ta; b = ~tb_; l = ~tl; sub = ~tsub;
  endtask

  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    while (!done && cyc < 3 * N) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!done) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                        input logic tl, input logic [1:0] ts, input logic tsub,
                        input logic [7:0] ey, input logic ec, input logic eov);
    int cyc;
    issue(ta, tb_, tl, ts, tsub);
    check({tag, "_busy"}, 32'(busy), 1);
    wait_done(tag, cyc);
    check({tag, "_lat"}, cyc, N);
    check({tag, "_y"}, 32'(y), 32'(ey));
    check({tag, "_cout"}, 32'(c_out), 32'(ec));
    check({tag, "_ov"}, 32'(ov), 32'(eov));
    @(posedge clk);
    #1;
    check({tag, "_done1cyc"}, 32'(done), 0);
    check({tag, "_idle"}, 32'(busy), 0);
    check({tag, "_yhold"}, 32'(y), 32'(ey));
  endtask

  initial begin
    int cyc, gap;
    logic seen_done;
    #3;
    check("rst_y", 32'(y), 0);
    check("rst_flags", {c_out, ov, busy, done}, 0);
    #10 reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_after_rst", 32'(busy), 0);

    run_op("add",     8'h5A, 8'h3C, 1'b0, 2'd0, 1'b0, 8'h96, 1'b1 ^ 1'b1, 1'b1);
    run_op("addwrap", 8'hFF, 8'h01, 1'b0, 2'd0, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("sub",     8'h10, 8'h01, 1'b0, 2'd0, 1'b1, 8'h0F, 1'b1, 1'b0);
    run_op("subov",   8'h80, 8'h01, 1'b0, 2'd0, 1'b1, 8'h7F, 1'b1, 1'b1);
    run_op("subbor",  8'h00, 8'h01, 1'b0, 2'd0, 1'b1, 8'hFF, 1'b0, 1'b0);
    run_op("and",     8'hF0, 8'hCC, 1'b1, 2'd0, 1'b1, 8'hC0, 1'b0, 1'b0);
    run_op("or",      8'hF0, 8'hCC, 1'b1, 2'd1, 1'b1, 8'hFC, 1'b0, 1'b0);
    run_op("xor",     8'hF0, 8'hCC, 1'b1, 2'd2, 1'b1, 8'h3C, 1'b0, 1'b0);
    run_op("nand",    8'hF0, 8'hCC, 1'b1, 2'd3, 1'b1, 8'h3F, 1'b0, 1'b0);

    // start pulses during RUN and DONE must be ignored
    issue(8'h5A, 8'h3C, 1'b0, 2'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    a = 8'h01; b = 8'h01; l = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ign", cyc);
    check("ign_y", 32'(y), 32'h96);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ign_done_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    check("ign_still_idle", 32'(busy), 0);
    check("ign_yhold", 32'(y), 32'h96);

    // held start: next acceptance N+2 edges after the first
    a = 8'hFF; b = 8'h01; l = 1'b0; s = 2'd0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    gap = 0;
    while (busy && gap < 3 * N) begin @(posedge clk); #1; gap++; end
    while (!busy && gap < 3 * N) begin @(posedge clk); #1; gap++; end
    check("b2b_gap", gap, N + 2);
    start = 1'b0;
    wait_done("b2b", cyc);
    check("b2b_y", 32'(y), 0);
    @(posedge clk);
    #1;

    // reset mid-RUN aborts with no done pulse
    issue(8'h5A, 8'h3C, 1'b0, 2'd0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_y", 32'(y), 0);
    check("abort_flags", {c_out, ov, busy, done}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    seen_done = 1'b0;
    repeat (N + 3) begin @(posedge clk); #1; seen_done |= done; end
    check("abort_nodone", 32'(seen_done), 0);
    run_op("post_rst", 8'h01, 8'h02, 1'b0, 2'd0, 1'b0, 8'h03, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
